// File: rtl/board_io_pkg.sv
// Shared constants for the DE10-Nano button/switch conditioning path.
package board_io_pkg;

    localparam int NUM_KEYS                = 2;
    localparam int NUM_SW                  = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_RESET_STRETCH   = 8;
    localparam int DB_CNT_W                = 8;

    typedef logic [DB_CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-flop synchroniser, stability counter, accepted level and
// registered rise/fall pulses that coincide with the first cycle of the new level.
module debounce_cell
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit IDLE_LEVEL      = 1'b0
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic    sync_meta;
    logic    sync_q;
    logic    sample;
    db_cnt_t cnt;

    // Normalise polarity so an idle pin always reads as 0.
    assign sample = sync_q ^ IDLE_LEVEL;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sync_meta <= IDLE_LEVEL;
            sync_q    <= IDLE_LEVEL;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_meta <= pin;
            sync_q    <= sync_meta;
            rise      <= 1'b0;
            fall      <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == db_cnt_t'(DEBOUNCE_CYCLES - 1)) begin
                level <= sample;
                rise  <= sample;
                fall  <= ~sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + db_cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions KEY[1:0] / SW[3:0] for the CPU and stretches cpu_reset.
// Define SW_DEBOUNCE_EN to debounce switches; otherwise they are only synchronised.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int RESET_STRETCH   = DEFAULT_RESET_STRETCH
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_SW-1:0]   sw_in,
    input  logic [NUM_KEYS-1:0] event_clear,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_event,
    output logic [NUM_SW-1:0]   sw_level,
    output logic                sw_change,
    output logic                cpu_reset
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (1'b1)
        ) u_db (
            .clock_in(clock_in),
            .reset_in(reset_in),
            .pin     (key_n_in[i]),
            .level   (key_level[i]),
            .rise    (key_press[i]),
            .fall    (key_release[i])
        );
    end

`ifdef SW_DEBOUNCE_EN
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (1'b0)
        ) u_db (
            .clock_in(clock_in),
            .reset_in(reset_in),
            .pin     (sw_in[i]),
            .level   (sw_level[i]),
            .rise    (sw_rise[i]),
            .fall    (sw_fall[i])
        );
    end

    assign sw_change = |(sw_rise | sw_fall);
`else
    logic [NUM_SW-1:0] sw_meta;
    logic [NUM_SW-1:0] sw_prev;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sw_meta  <= '0;
            sw_level <= '0;
            sw_prev  <= '0;
        end else begin
            sw_meta  <= sw_in;
            sw_level <= sw_meta;
            sw_prev  <= sw_level;
        end
    end

    assign sw_change = |(sw_level ^ sw_prev);
`endif

    // Handshake: key_press sets a flag, event_clear drops it on the next
    // edge; a press arriving in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            key_event <= '0;
        end else begin
            key_event <= key_press | (key_event & ~event_clear);
        end
    end

    logic    rst_src_q;
    db_cnt_t stretch_cnt;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rst_src_q   <= 1'b1;
            stretch_cnt <= db_cnt_t'(RESET_STRETCH);
        end else begin
            rst_src_q <= key_level[0];
            if (rst_src_q) begin
                stretch_cnt <= db_cnt_t'(RESET_STRETCH);
            end else if (stretch_cnt != '0) begin
                stretch_cnt <= stretch_cnt - db_cnt_t'(1);
            end
        end
    end

    // key_level[0] is included so the CPU is held from the very cycle KEY[0] is accepted.
    assign cpu_reset = key_level[0] | rst_src_q | (stretch_cnt != '0);

endmodule
